// File: rtl/cpu_ls_pkg.sv
// Shared definitions for the cpu_ls multicycle load/store CPU:
// sizes, instruction field positions, opcodes and FSM state encoding.
package cpu_ls_pkg;

   localparam int NREG      = 4;
   localparam int RAM_DEPTH = 256;
   localparam int DW        = 16;

   localparam int OP_HI  = 15;
   localparam int OP_LO  = 12;
   localparam int RD_HI  = 11;
   localparam int RD_LO  = 10;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;

   localparam logic [3:0] OP_MOV = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_AND = 4'b0110;
   localparam logic [3:0] OP_OR  = 4'b1000;
   localparam logic [3:0] OP_JMP = 4'b1100;
   localparam logic [3:0] OP_ST  = 4'b1101;
   localparam logic [3:0] OP_LD  = 4'b1110;

   typedef enum logic {
      S_FETCH = 1'b0,
      S_EXEC  = 1'b1
   } state_t;

   function automatic logic [DW-1:0] sext8(input logic [7:0] v);
      return {{(DW-8){v[7]}}, v};
   endfunction

endpackage

// File: rtl/cpu_ls_alu.sv
// Combinational ALU: computes the register result for MOV/ADD/SUB/AND/OR.
// Any other opcode passes the current rd value through unchanged.
module cpu_ls_alu
   import cpu_ls_pkg::*;
(
   input  logic [3:0]    op,
   input  logic [DW-1:0] rd_val,
   input  logic [DW-1:0] imm,
   output logic [DW-1:0] result
);

   always_comb begin
      result = rd_val;
      case (op)
         OP_MOV:  result = imm;
         OP_ADD:  result = rd_val + imm;
         OP_SUB:  result = rd_val - imm;
         OP_AND:  result = rd_val & imm;
         OP_OR:   result = rd_val | imm;
         default: result = rd_val;
      endcase
   end

endmodule

// File: rtl/cpu_ls.sv
// Two-step (FETCH/EXEC) 16-bit CPU with 4 registers and a 256-word data RAM.
// Instructions arrive on ins; the low byte of the last register write drives led.
module cpu_ls
   import cpu_ls_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          en_in,
   input  logic          en2,
   input  logic [15:0]   ins,
   output logic [7:0]    led,
   output logic [15:0]   pc_out
);

   state_t        state_q, state_d;
   logic [15:0]   ir_q, ir_d;
   logic [DW-1:0] pc_q, pc_d;
   logic [7:0]    led_q, led_d;
   logic [DW-1:0] regs_q [NREG];
   logic [DW-1:0] regs_d [NREG];
   logic [DW-1:0] ram_q  [RAM_DEPTH];

   logic          step;
   logic [3:0]    op;
   logic [1:0]    rd;
   logic [7:0]    imm8;
   logic [DW-1:0] rd_val;
   logic [DW-1:0] alu_res;
   logic [DW-1:0] wb_val;
   logic          wb_en;
   logic          ram_we;
   logic          unused_ir_bits;

   assign step   = en_in & en2;
   assign op     = ir_q[OP_HI:OP_LO];
   assign rd     = ir_q[RD_HI:RD_LO];
   assign imm8   = ir_q[IMM_HI:IMM_LO];
   assign rd_val = regs_q[rd];
   assign unused_ir_bits = ^ir_q[9:8];

   cpu_ls_alu u_alu (
      .op     (op),
      .rd_val (rd_val),
      .imm    ({8'h00, imm8}),
      .result (alu_res)
   );

   // LD bypasses the ALU and takes the asynchronous RAM read instead
   assign wb_val = (op == OP_LD) ? ram_q[imm8] : alu_res;
   assign wb_en  = (op == OP_MOV) || (op == OP_ADD) || (op == OP_SUB) ||
                   (op == OP_AND) || (op == OP_OR)  || (op == OP_LD);
   assign ram_we = step && (state_q == S_EXEC) && (op == OP_ST);

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      pc_d    = pc_q;
      led_d   = led_q;
      regs_d  = regs_q;
      if (step) begin
         case (state_q)
            S_FETCH: begin
               ir_d    = ins;
               state_d = S_EXEC;
            end
            default: begin
               state_d = S_FETCH;
               pc_d    = (op == OP_JMP) ? pc_q + sext8(imm8) : pc_q + 16'd1;
               if (wb_en) begin
                  regs_d[rd] = wb_val;
                  led_d      = wb_val[7:0];
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_FETCH;
         ir_q    <= '0;
         pc_q    <= '0;
         led_q   <= '0;
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         pc_q    <= pc_d;
         led_q   <= led_d;
         regs_q  <= regs_d;
      end
   end

   // RAM has no reset so its contents survive a CPU reset
   always_ff @(posedge clk) begin
      if (ram_we) ram_q[imm8] <= rd_val;
   end

   assign led    = led_q;
   assign pc_out = pc_q;

endmodule

// File: tb/tb_cpu_ls.sv
// Self-checking bench for cpu_ls: table-driven instruction vectors with a
// scoreboard of expected led/pc, plus reset, freeze and mid-op reset sequences.
module tb_cpu_ls;
   import cpu_ls_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en_in = 1'b0;
   logic        en2 = 1'b0;
   logic [15:0] ins = 16'h0000;
   logic [7:0]  led;
   logic [15:0] pc_out;

   cpu_ls dut (
      .clk    (clk),
      .rst    (rst),
      .en_in  (en_in),
      .en2    (en2),
      .ins    (ins),
      .led    (led),
      .pc_out (pc_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] ins;
      logic [7:0]  led;
      logic [15:0] pc;
   } vec_t;

   typedef struct {
      logic [7:0]  led;
      logic [15:0] pc;
   } exp_t;

   localparam int NVEC = 28;
   vec_t vecs [NVEC];
   exp_t sb_q [$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] r,
                                      input logic [7:0] imm);
      return {op, r, 2'b00, imm};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One instruction: FETCH step, garbage on ins, EXEC step; en2 every 2nd clk
   task automatic issue(input string tag, input logic [15:0] i,
                        input logic [7:0] e_led, input logic [15:0] e_pc);
      exp_t e;
      sb_q.push_back('{e_led, e_pc});
      @(negedge clk); ins = i; en2 = 1'b1;
      @(negedge clk); en2 = 1'b0; ins = 16'($urandom);
      @(negedge clk); en2 = 1'b1;
      @(negedge clk); en2 = 1'b0;
      e = sb_q.pop_front();
      $display("txn %s ins=%h led=%h pc=%h", tag, i, led, pc_out);
      chk({tag, " led"}, {24'h0, led}, {24'h0, e.led});
      chk({tag, " pc"},  {16'h0, pc_out}, {16'h0, e.pc});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{mk(OP_MOV, 2'd1, 8'h01), 8'h01, 16'd1};
      vecs[1]  = '{mk(OP_ADD, 2'd1, 8'h01), 8'h02, 16'd2};
      vecs[2]  = '{mk(OP_ADD, 2'd1, 8'h02), 8'h04, 16'd3};
      vecs[3]  = '{mk(OP_ADD, 2'd1, 8'h04), 8'h08, 16'd4};
      vecs[4]  = '{mk(OP_ADD, 2'd1, 8'h08), 8'h10, 16'd5};
      vecs[5]  = '{mk(OP_ADD, 2'd1, 8'h10), 8'h20, 16'd6};
      vecs[6]  = '{mk(OP_ADD, 2'd1, 8'h20), 8'h40, 16'd7};
      vecs[7]  = '{mk(OP_ADD, 2'd1, 8'h40), 8'h80, 16'd8};
      vecs[8]  = '{mk(OP_SUB, 2'd1, 8'h40), 8'h40, 16'd9};
      vecs[9]  = '{mk(OP_SUB, 2'd1, 8'h20), 8'h20, 16'd10};
      vecs[10] = '{mk(OP_OR,  2'd1, 8'h81), 8'hA1, 16'd11};
      vecs[11] = '{mk(OP_AND, 2'd1, 8'h29), 8'h21, 16'd12};
      vecs[12] = '{mk(OP_JMP, 2'd0, 8'h03), 8'h21, 16'd15};
      vecs[13] = '{mk(OP_JMP, 2'd0, 8'hFE), 8'h21, 16'd13};
      vecs[14] = '{mk(OP_MOV, 2'd0, 8'h00), 8'h00, 16'd14};
      vecs[15] = '{mk(OP_ST,  2'd0, 8'h22), 8'h00, 16'd15};
      vecs[16] = '{mk(OP_MOV, 2'd1, 8'h55), 8'h55, 16'd16};
      vecs[17] = '{mk(OP_LD,  2'd1, 8'h22), 8'h00, 16'd17};
      vecs[18] = '{mk(OP_MOV, 2'd3, 8'h00), 8'h00, 16'd18};
      vecs[19] = '{mk(OP_SUB, 2'd3, 8'hCC), 8'h34, 16'd19};
      vecs[20] = '{mk(OP_ST,  2'd3, 8'h10), 8'h34, 16'd20};
      vecs[21] = '{mk(OP_MOV, 2'd2, 8'h99), 8'h99, 16'd21};
      vecs[22] = '{mk(OP_LD,  2'd2, 8'h10), 8'h34, 16'd22};
      vecs[23] = '{mk(OP_ADD, 2'd2, 8'hCC), 8'h00, 16'd23};
      vecs[24] = '{16'h15FF,                8'h00, 16'd24};
      vecs[25] = '{mk(OP_ADD, 2'd1, 8'h01), 8'h01, 16'd25};
      vecs[26] = '{mk(OP_JMP, 2'd0, 8'h80), 8'h01, 16'hFF99};
      vecs[27] = '{mk(OP_JMP, 2'd0, 8'h7F), 8'h01, 16'h0018};

      // Reset held with enable low, en2 toggling
      #1 rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); en2 = ~en2;
      end
      chk("reset pc", {16'h0, pc_out}, 32'h0);
      chk("reset led", {24'h0, led}, 32'h0);
      @(negedge clk); rst = 1'b1; en2 = 1'b0;
      ins = mk(OP_MOV, 2'd0, 8'hAA);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk); en2 = ~en2;
      end
      @(negedge clk); en2 = 1'b0;
      $display("txn disabled-steps led=%h pc=%h", led, pc_out);
      chk("disabled pc", {16'h0, pc_out}, 32'h0);
      chk("disabled led", {24'h0, led}, 32'h0);
      en_in = 1'b1;

      for (int v = 0; v < NVEC; v++)
         issue($sformatf("vec%0d", v), vecs[v].ins, vecs[v].led, vecs[v].pc);

      // Freeze between FETCH and EXEC: IR must hold despite en2 and ins activity
      @(negedge clk); ins = mk(OP_MOV, 2'd2, 8'h77); en2 = 1'b1;
      @(negedge clk); en2 = 1'b0; en_in = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk); en2 = ~en2; ins = mk(OP_MOV, 2'd2, 8'(k + 1));
      end
      @(negedge clk); en2 = 1'b0;
      $display("txn frozen led=%h pc=%h", led, pc_out);
      chk("freeze pc", {16'h0, pc_out}, 32'h18);
      chk("freeze led", {24'h0, led}, 32'h01);
      en_in = 1'b1; en2 = 1'b1; ins = 16'hFFFF;
      @(negedge clk); en2 = 1'b0;
      $display("txn unfrozen-exec led=%h pc=%h", led, pc_out);
      chk("unfreeze led", {24'h0, led}, 32'h77);
      chk("unfreeze pc", {16'h0, pc_out}, 32'h19);

      // Asynchronous reset while in EXEC, observed before the next clock edge
      @(negedge clk); ins = mk(OP_MOV, 2'd1, 8'hEE); en2 = 1'b1;
      @(negedge clk); en2 = 1'b0;
      #2 rst = 1'b0;
      #1;
      $display("txn async-reset led=%h pc=%h", led, pc_out);
      chk("async rst pc", {16'h0, pc_out}, 32'h0);
      chk("async rst led", {24'h0, led}, 32'h0);
      @(negedge clk); rst = 1'b1;

      issue("post-rst r3", mk(OP_ADD, 2'd3, 8'h00), 8'h00, 16'd1);
      issue("post-rst ram10", mk(OP_LD, 2'd0, 8'h10), 8'h34, 16'd2);
      issue("post-rst r2", mk(OP_ADD, 2'd2, 8'h00), 8'h00, 16'd3);
      issue("post-rst r0", mk(OP_ADD, 2'd0, 8'h01), 8'h35, 16'd4);

      chk("scoreboard empty", 32'(sb_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
